// File: rtl/alu_cmd_issuer_if.sv
// Host command/result channels and ALU BEGIN/END operand channel bundled together.
// slave is the issuer's view; master is the host-and-ALU environment's view.
interface alu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_X;
    logic [7:0]  alu_Y;
    logic [2:0]  alu_op;
    logic        alu_begin;
    logic [15:0] alu_out;
    logic        alu_end;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_op;
    logic        res_err;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_op, alu_out, alu_end, res_ready,
        output cmd_ready, alu_X, alu_Y, alu_op, alu_begin, res_valid, res_data, res_op,
               res_err, busy
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_op, alu_out, alu_end, res_ready,
        input  cmd_ready, alu_X, alu_Y, alu_op, alu_begin, res_valid, res_data, res_op,
               res_err, busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers host ALU commands in a FIFO and issues them one at a time over the
// BEGIN/END handshake, returning each result (or a timeout error) to the host.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic              clk,
    input logic              resetn,
    alu_cmd_issuer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [18:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic [2:0]    r_op;
    logic [15:0]   r_res_data;
    logic [2:0]    r_res_op;
    logic          r_res_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_cap_ok;
    logic          w_cap_to;
    logic          w_cnt_max;
    logic [18:0]   w_head;

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push    = bus.cmd_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_cnt_max = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {bus.cmd_x, bus.cmd_y, bus.cmd_op};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= StIdle;
        else         r_state <= w_state_nxt;
    end

    // END beats a coincident timeout; DRAIN holds until a stale END level clears.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cap_ok    = 1'b0;
        w_cap_to    = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: w_state_nxt = StWait;
            StWait: begin
                if (bus.alu_end) begin
                    w_cap_ok    = 1'b1;
                    w_state_nxt = StResp;
                end else if (w_cnt_max) begin
                    w_cap_to    = 1'b1;
                    w_state_nxt = StResp;
                end
            end
            StResp:  if (bus.res_ready) w_state_nxt = StDrain;
            StDrain: if (!bus.alu_end)  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Saturating so a late END can never alias a wrapped count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == StIssue) begin
            r_cnt <= '0;
        end else if (r_state == StWait && !w_cnt_max) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x        <= '0;
            r_y        <= '0;
            r_op       <= '0;
            r_res_data <= '0;
            r_res_op   <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if (w_pop) begin
                {r_x, r_y, r_op} <= w_head;
            end
            if (w_cap_ok) begin
                r_res_data <= bus.alu_out;
                r_res_op   <= r_op;
                r_res_err  <= 1'b0;
            end else if (w_cap_to) begin
                r_res_data <= '0;
                r_res_op   <= r_op;
                r_res_err  <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.alu_X     = r_x;
    assign bus.alu_Y     = r_y;
    assign bus.alu_op    = r_op;
    assign bus.alu_begin = (r_state == StIssue);
    assign bus.res_valid = (r_state == StResp);
    assign bus.res_data  = r_res_data;
    assign bus.res_op    = r_res_op;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = (r_state != StIdle);
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU that answers X+Y
// after a configurable latency, optionally holding END high or never answering.
module tb_alu_cmd_issuer;
    logic clk = 1'b0;
    logic resetn;

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int lat_cfg   = 6;
    int hold_cfg  = 1;
    bit never_cfg = 1'b0;

    int          begin_cnt = 0;
    int          cyc       = 0;
    int          begin_cyc[$];
    int          m_cnt;
    int          m_hold;
    logic [15:0] m_val;

    // ALU model runs on the falling edge so its outputs are settled by the next rise.
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            bus.alu_end = 1'b0;
            bus.alu_out = '0;
            m_cnt       = 0;
            m_hold      = 0;
        end else begin
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) bus.alu_end = 1'b0;
            end
            if (bus.alu_begin) begin
                begin_cnt++;
                begin_cyc.push_back(cyc);
                bus.alu_end = 1'b0;
                m_hold      = 0;
                m_val       = {8'h00, bus.alu_X} + {8'h00, bus.alu_Y};
                m_cnt       = never_cfg ? 0 : lat_cfg;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    bus.alu_end = 1'b1;
                    bus.alu_out = m_val;
                    m_hold      = hold_cfg;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_op    = op;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_begin(input string tag);
        int n = 0;
        while (!bus.alu_begin && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_begin"}, 32'(bus.alu_begin), 32'd1);
    endtask

    task automatic wait_res(input string tag, input logic [15:0] d, input logic [2:0] op,
                            input logic err);
        int n = 0;
        while (!bus.res_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_data"},  32'(bus.res_data),  32'(d));
        check({tag, "_op"},    32'(bus.res_op),    32'(op));
        check({tag, "_err"},   32'(bus.res_err),   32'(err));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          b;
        int          nb;
        bit          stable;
        logic [15:0] sd;
        logic [2:0]  so;
        logic        se;

        resetn        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_op    = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_alu_begin", 32'(bus.alu_begin), 32'd0);
        check("rst_alu_x",     32'(bus.alu_X),     32'd0);
        check("rst_res_data",  32'(bus.res_data),  32'd0);
        resetn = 1'b1;
        repeat (2) tick();

        // Single op: latency, operand stability, result.
        push(8'h05, 8'h03, 3'b000);
        tick();
        check("t1_begin_lat", 32'(bus.alu_begin), 32'd1);
        check("t1_alu_x",     32'(bus.alu_X),     32'h05);
        n      = 0;
        stable = 1'b1;
        while (!bus.res_valid && n < 100) begin
            tick();
            n++;
            if (bus.alu_X != 8'h05 || bus.alu_Y != 8'h03) stable = 1'b0;
        end
        check("t1_begin_to_valid", 32'(n), 32'd7);
        wait_res("t1", 16'h0008, 3'b000, 1'b0);
        check("t1_drain_alu_x", 32'(bus.alu_X), 32'h05);
        check("t1_drain_busy",  32'(bus.busy),  32'd1);
        check("t1_x_stable",    32'(stable),    32'd1);
        repeat (3) tick();
        check("t1_begin_count", 32'(begin_cnt), 32'd1);

        // FIFO fill with result backpressure.
        lat_cfg = 3;
        for (int i = 1; i <= 5; i++) push(8'(i), 8'h00, 3'(i));
        check("t2_full", 32'(bus.cmd_ready), 32'd0);
        n = 0;
        while (!bus.res_valid && n < 100) begin
            tick();
            n++;
        end
        check("t2_first_valid", 32'(bus.res_valid), 32'd1);
        sd     = bus.res_data;
        so     = bus.res_op;
        se     = bus.res_err;
        b      = begin_cnt;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!bus.res_valid || bus.res_data != sd || bus.res_op != so || bus.res_err != se)
                stable = 1'b0;
        end
        check("t5_hold_stable", 32'(stable),      32'd1);
        check("t5_no_begin",    32'(begin_cnt),   32'(b));
        check("t2_still_full",  32'(bus.cmd_ready), 32'd0);
        wait_res("t2_r1", 16'h0001, 3'd1, 1'b0);
        n = 0;
        while (!bus.cmd_ready && n < 5) begin
            tick();
            n++;
        end
        check("t2_ready_back", 32'(bus.cmd_ready), 32'd1);
        wait_res("t2_r2", 16'h0002, 3'd2, 1'b0);
        wait_res("t2_r3", 16'h0003, 3'd3, 1'b0);
        wait_res("t2_r4", 16'h0004, 3'd4, 1'b0);
        wait_res("t2_r5", 16'h0005, 3'd5, 1'b0);
        repeat (3) tick();

        // Timeout, then normal recovery.
        never_cfg = 1'b1;
        push(8'h07, 8'h07, 3'd2);
        wait_begin("t3");
        n = 0;
        while (!bus.res_valid && n < 200) begin
            tick();
            n++;
        end
        check("t3_begin_to_valid", 32'(n), 32'd65);
        wait_res("t3", 16'h0000, 3'd2, 1'b1);
        never_cfg = 1'b0;
        lat_cfg   = 3;
        push(8'h02, 8'h03, 3'd1);
        wait_res("t3_next", 16'h0005, 3'd1, 1'b0);
        repeat (3) tick();

        // Sticky END: second BEGIN must wait for END to fall.
        lat_cfg  = 4;
        hold_cfg = 10;
        nb       = begin_cyc.size();
        push(8'h01, 8'h01, 3'd3);
        push(8'hFF, 8'h01, 3'd4);
        wait_res("t4_a", 16'h0002, 3'd3, 1'b0);
        wait_res("t4_b", 16'h0100, 3'd4, 1'b0);
        if (begin_cyc.size() >= nb + 2)
            check("t4_begin_gap", 32'(begin_cyc[nb+1] - begin_cyc[nb]), 32'd16);
        else
            check("t4_begin_num", 32'(begin_cyc.size()), 32'(nb + 2));
        hold_cfg = 1;
        repeat (15) tick();

        // Reset mid-WAIT abandons the command.
        lat_cfg = 20;
        push(8'h09, 8'h09, 3'd0);
        wait_begin("t6");
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        check("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("t6_res_valid", 32'(bus.res_valid), 32'd0);
        check("t6_busy",      32'(bus.busy),      32'd0);
        check("t6_alu_begin", 32'(bus.alu_begin), 32'd0);
        check("t6_alu_x",     32'(bus.alu_X),     32'd0);
        check("t6_alu_y",     32'(bus.alu_Y),     32'd0);
        check("t6_alu_op",    32'(bus.alu_op),    32'd0);
        check("t6_res_data",  32'(bus.res_data),  32'd0);
        check("t6_res_op",    32'(bus.res_op),    32'd0);
        check("t6_res_err",   32'(bus.res_err),   32'd0);
        tick();
        resetn = 1'b1;
        b      = begin_cnt;
        stable = 1'b1;
        repeat (30) begin
            tick();
            if (bus.res_valid || bus.busy) stable = 1'b0;
        end
        check("t6_quiet",    32'(stable),    32'd1);
        check("t6_no_begin", 32'(begin_cnt), 32'(b));
        lat_cfg = 3;
        push(8'h04, 8'h06, 3'd5);
        wait_res("t6_next", 16'h000A, 3'd5, 1'b0);
        repeat (5) tick();
        check("begin_total", 32'(begin_cnt), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
